// File: rtl/display_7seg_varredura_if.sv
// Display bus between the datapath (master) and the scanned seven-segment
// driver (slave): digit codes, load strobe, blanking enable, segments, anodes.
interface display_7seg_varredura_if #(
    parameter int N_DIGITOS = 4
);
    logic [4*N_DIGITOS-1:0] valores;
    logic                   carregar;
    logic                   supressao_zeros;
    logic [0:6]             decimal;
    logic [N_DIGITOS-1:0]   anodo;

    modport master (
        output valores,
        output carregar,
        output supressao_zeros,
        input  decimal,
        input  anodo
    );

    modport slave (
        input  valores,
        input  carregar,
        input  supressao_zeros,
        output decimal,
        output anodo
    );
endinterface

// File: rtl/display_7seg_varredura.sv
// Time-multiplexed seven-segment driver: latches N 4-bit digit codes and scans
// them one digit at a time, with optional leading-zero blanking.
// Build option: define DISPLAY_7SEG_HEXA_EN to show codes 10..15 as A,b,C,d,E,F;
// otherwise those codes show segment g only as an error marker.
module display_7seg_varredura #(
    parameter int N_DIGITOS     = 4,
    parameter int DIV_VARREDURA = 50000
) (
    input  logic clk,
    input  logic rst_n,
    display_7seg_varredura_if.slave bus
);
    localparam int CW = (DIV_VARREDURA > 1) ? $clog2(DIV_VARREDURA) : 1;
    localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
    localparam logic [CW-1:0] CONT_MAX = CW'(DIV_VARREDURA - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(N_DIGITOS - 1);

    logic [4*N_DIGITOS-1:0] valores_reg;
    logic [CW-1:0]          cont_reg;
    logic [IW-1:0]          indice_reg;
    logic [0:6]             decimal_reg;
    logic [N_DIGITOS-1:0]   anodo_reg;

    logic [3:0]             digito [N_DIGITOS];
    logic [N_DIGITOS-1:0]   apagavel;
    logic [N_DIGITOS-1:0]   anodo_next;
    logic [3:0]             codigo;
    logic                   apagar;
    logic [0:6]             segmentos;
    logic [0:6]             decimal_next;

    // Split the latched vector into individual digit codes
    generate
        for (genvar gi = 0; gi < N_DIGITOS; gi++) begin : g_digito
            assign digito[gi] = valores_reg[4*gi +: 4];
        end
    endgenerate

    // Digit i>0 may be blanked when it and every more significant digit are 0
    always_comb begin
        logic todos_zero;
        apagavel   = '0;
        todos_zero = 1'b1;
        for (int i = N_DIGITOS - 1; i >= 1; i--) begin
            todos_zero  = todos_zero && (valores_reg[4*i +: 4] == 4'd0);
            apagavel[i] = todos_zero;
        end
    end

    // Select the active digit's code, blank flag and one-hot anode
    always_comb begin
        codigo     = 4'd0;
        apagar     = 1'b0;
        anodo_next = '0;
        for (int i = 0; i < N_DIGITOS; i++) begin
            if (indice_reg == IW'(i)) begin
                codigo        = digito[i];
                apagar        = apagavel[i];
                anodo_next[i] = 1'b1;
            end
        end
    end

    // Code to a..g segment pattern (bit 0 = a)
    always_comb begin
        segmentos = 7'b0000001;
        unique case (codigo)
            4'd0:  segmentos = 7'b1111110;
            4'd1:  segmentos = 7'b0110000;
            4'd2:  segmentos = 7'b1101101;
            4'd3:  segmentos = 7'b1111001;
            4'd4:  segmentos = 7'b0110011;
            4'd5:  segmentos = 7'b1011011;
            4'd6:  segmentos = 7'b1011111;
            4'd7:  segmentos = 7'b1110000;
            4'd8:  segmentos = 7'b1111111;
            4'd9:  segmentos = 7'b1111011;
`ifdef DISPLAY_7SEG_HEXA_EN
            4'd10: segmentos = 7'b1110111;
            4'd11: segmentos = 7'b0011111;
            4'd12: segmentos = 7'b1001110;
            4'd13: segmentos = 7'b0111101;
            4'd14: segmentos = 7'b1001111;
            4'd15: segmentos = 7'b1000111;
`else
            4'd10, 4'd11, 4'd12,
            4'd13, 4'd14, 4'd15: segmentos = 7'b0000001;
`endif
            default: segmentos = 7'b0000001;
        endcase
        decimal_next = (bus.supressao_zeros && apagar) ? 7'b0000000 : segmentos;
    end

    // Load register, prescaler, digit index and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valores_reg <= '0;
            cont_reg    <= '0;
            indice_reg  <= '0;
            decimal_reg <= '0;
            anodo_reg   <= '0;
        end else begin
            if (bus.carregar) begin
                valores_reg <= bus.valores;
            end
            if (cont_reg == CONT_MAX) begin
                cont_reg   <= '0;
                indice_reg <= (indice_reg == IDX_MAX) ? '0 : indice_reg + 1'b1;
            end else begin
                cont_reg <= cont_reg + 1'b1;
            end
            decimal_reg <= decimal_next;
            anodo_reg   <= anodo_next;
        end
    end

    assign bus.decimal = decimal_reg;
    assign bus.anodo   = anodo_reg;

endmodule

// File: tb/tb_display_7seg_varredura.sv
// Bench for display_7seg_varredura: a 4-digit/DIV=3 instance and a 1-digit/DIV=1
// instance, checked every cycle against an elapsed-time reference model.
module tb_display_7seg_varredura;
    localparam int N_A   = 4;
    localparam int DIV_A = 3;

    logic clk = 1'b0;
    logic rst_n;

    display_7seg_varredura_if #(.N_DIGITOS(N_A)) bus_a ();
    display_7seg_varredura_if #(.N_DIGITOS(1))   bus_b ();

    display_7seg_varredura #(.N_DIGITOS(N_A), .DIV_VARREDURA(DIV_A)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    display_7seg_varredura #(.N_DIGITOS(1), .DIV_VARREDURA(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: edges since reset release and the latched digits
    int         k;
    logic [3:0] vals_a [N_A];
    logic [3:0] val_b;
    logic [3:0] exp_an_a;
    logic [0:6] exp_dec_a;
    logic       exp_an_b;
    logic [0:6] exp_dec_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [0:6] seg(input logic [3:0] c);
        case (c)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
`ifdef DISPLAY_7SEG_HEXA_EN
            4'd10: return 7'b1110111;
            4'd11: return 7'b0011111;
            4'd12: return 7'b1001110;
            4'd13: return 7'b0111101;
            4'd14: return 7'b1001111;
            default: return 7'b1000111;
`else
            default: return 7'b0000001;
`endif
        endcase
    endfunction

    // One clock edge: advance the model, then compare both instances
    task automatic tick();
        int  idx;
        logic blank;
        @(posedge clk);
        if (!rst_n) begin
            k = 0;
            for (int j = 0; j < N_A; j++) vals_a[j] = 4'd0;
            val_b     = 4'd0;
            exp_an_a  = 4'b0000;
            exp_dec_a = 7'b0000000;
            exp_an_b  = 1'b0;
            exp_dec_b = 7'b0000000;
        end else begin
            idx      = (k / DIV_A) % N_A;
            exp_an_a = 4'b0001 << idx;
            blank    = bus_a.supressao_zeros && (idx > 0);
            for (int j = idx; j < N_A; j++) if (vals_a[j] != 4'd0) blank = 1'b0;
            exp_dec_a = blank ? 7'b0000000 : seg(vals_a[idx]);
            if (bus_a.carregar)
                for (int j = 0; j < N_A; j++) vals_a[j] = bus_a.valores[4*j +: 4];
            exp_an_b  = 1'b1;
            exp_dec_b = seg(val_b);
            if (bus_b.carregar) val_b = bus_b.valores;
            k++;
        end
        #1;
        check("anodo_a",   32'(bus_a.anodo),   32'(exp_an_a));
        check("decimal_a", 32'(bus_a.decimal), 32'(exp_dec_a));
        check("anodo_b",   32'(bus_b.anodo),   32'(exp_an_b));
        check("decimal_b", 32'(bus_b.decimal), 32'(exp_dec_b));
    endtask

    task automatic load_a(input logic [15:0] v, input logic sup);
        $display("load_a valores=%04h supressao=%0d", v, sup);
        bus_a.valores         = v;
        bus_a.supressao_zeros = sup;
        bus_a.carregar        = 1'b1;
        tick();
        bus_a.carregar = 1'b0;
        bus_a.valores  = 16'($urandom);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n                 = 1'b0;
        bus_a.valores         = '0;
        bus_a.carregar        = 1'b0;
        bus_a.supressao_zeros = 1'b0;
        bus_b.valores         = '0;
        bus_b.carregar        = 1'b0;
        bus_b.supressao_zeros = 1'b0;
        run(2);
        check("reset_anodo", 32'(bus_a.anodo), 32'd0);

        // Scan with nothing loaded
        rst_n = 1'b1;
        tick();
        check("first_digit0", 32'(bus_a.decimal), 32'(7'b1111110));
        run(14);

        // Load 0x4321 at an edge where digit 0 is about to be shown
        for (int g = 0; g < 24 && ((k / DIV_A) % N_A) != 3; g++) tick();
        for (int g = 0; g < 4 && ((k / DIV_A) % N_A) != 0; g++) tick();
        load_a(16'h4321, 1'b0);
        tick();
        check("load_latency", 32'(bus_a.decimal), 32'(7'b0110000));
        for (int i = 0; i < 12; i++) begin
            tick();
            if (exp_an_a == 4'b1000) check("dig3_4321", 32'(bus_a.decimal), 32'(7'b0110011));
        end

        // Leading-zero suppression on and off
        load_a(16'h0070, 1'b1);
        run(13);
        bus_a.supressao_zeros = 1'b0;
        run(13);

        // Codes above 9
        load_a(16'hFA00, 1'b0);
        run(13);

        // Reset while digit 2 is active with the prescaler at 1
        for (int g = 0; g < 24 && (k % (N_A * DIV_A)) != 7; g++) tick();
        rst_n = 1'b0;
        tick();
        check("midscan_anodo",   32'(bus_a.anodo),   32'd0);
        check("midscan_decimal", 32'(bus_a.decimal), 32'd0);
        rst_n = 1'b1;
        run(13);

        // Single-digit instance: direct loads
        bus_b.valores  = 4'd7;
        bus_b.carregar = 1'b1;
        tick();
        bus_b.carregar = 1'b0;
        tick();
        check("b_load_7", 32'(bus_b.decimal), 32'(7'b1110000));

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            rst_n                 = ($urandom_range(0, 49) != 0);
            bus_a.carregar        = ($urandom_range(0, 4) == 0);
            bus_a.supressao_zeros = 1'($urandom);
            for (int j = 0; j < N_A; j++)
                bus_a.valores[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            bus_b.carregar        = ($urandom_range(0, 2) == 0);
            bus_b.supressao_zeros = 1'($urandom);
            bus_b.valores         = 4'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
